// File: rtl/ddfs_pkg.sv
// ddfs_pkg: shared widths, range table and reset code for the DDFS frequency converter.
`default_nettype none

package ddfs_pkg;

  localparam int FW_W       = 7;
  localparam int FREQ_W     = 23;
  localparam int CTRL_W     = 3;
  localparam int NUM_RANGES = 7;

  localparam logic [CTRL_W-1:0] RST_CODE = 3'd6;

  // Clock-divider bank ratios, indexed by range code.
  function automatic logic [63:0] div_ratio(input int k);
    case (k)
      0:       div_ratio = 64'd2;
      1:       div_ratio = 64'd10;
      2:       div_ratio = 64'd100;
      3:       div_ratio = 64'd1000;
      4:       div_ratio = 64'd10000;
      5:       div_ratio = 64'd100000;
      default: div_ratio = 64'd1000000;
    endcase
  endfunction

  function automatic logic [63:0] fdiv(input logic [63:0] clk_freq, input int k);
    fdiv = clk_freq / div_ratio(k);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ddfs_fw_calc.sv
// ddfs_fw_calc: combinational frequency-word calculation for a given range code.
// DDFS_ROUND_EN selects round-half-up; otherwise the quotient is truncated.
`default_nettype none

module ddfs_fw_calc
  import ddfs_pkg::*;
#(
  parameter logic [63:0] CLK_FREQ = 64'd200000000
) (
  input  logic [FREQ_W-1:0] i_freq,
  input  logic [CTRL_W-1:0] i_code,
  output logic [FW_W-1:0]   o_fw
);

  logic [63:0] w_prod;
  logic [63:0] w_q [NUM_RANGES];
  logic [63:0] w_n;

  assign w_prod = {31'b0, i_freq, 10'b0};

  // One constant divider per range keeps every divisor a literal.
  for (genvar k = 0; k < NUM_RANGES; k++) begin : g_range
    localparam logic [63:0] c_FDIV = fdiv(CLK_FREQ, k);
`ifdef DDFS_ROUND_EN
    assign w_q[k] = (w_prod + (c_FDIV >> 1)) / c_FDIV;
`else
    assign w_q[k] = w_prod / c_FDIV;
`endif
  end

  always_comb begin
    w_n = 64'd0;
    for (int k = 0; k < NUM_RANGES; k++) begin
      if (i_code == CTRL_W'(k)) w_n = w_q[k];
    end
  end

  always_comb begin
    o_fw = '0;
    if (w_n == 64'd0)        o_fw = '0;
    else if (w_n >= 64'd128) o_fw = 7'd127;
    else                     o_fw = w_n[FW_W-1:0] - 7'd1;
  end

endmodule

`default_nettype wire

// File: rtl/ddfs_frequency_converter.sv
// ddfs_frequency_converter: maps a requested Hz value to a DDFS word and divider range, 1-cycle latency.
// Rounding mode follows DDFS_ROUND_EN (see ddfs_fw_calc).
`default_nettype none

module ddfs_frequency_converter
  import ddfs_pkg::*;
#(
  parameter logic [63:0] CLK_FREQ = 64'd200000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FREQ_W-1:0] freq_C2,
  output logic [FW_W-1:0]   fw,
  output logic [CTRL_W-1:0] freq_control
);

  logic [63:0]       w_scaled;
  logic [CTRL_W-1:0] w_code;
  logic [FW_W-1:0]   w_fw;
  logic [FW_W-1:0]   r_fw;
  logic [CTRL_W-1:0] r_ctrl;

  assign w_scaled = {38'b0, freq_C2, 3'b0};

  // Ascending scan: the last qualifying range is the finest one.
  always_comb begin
    w_code = '0;
    for (int k = 0; k < NUM_RANGES; k++) begin
      if (w_scaled <= fdiv(CLK_FREQ, k)) w_code = CTRL_W'(k);
    end
  end

  ddfs_fw_calc #(
    .CLK_FREQ (CLK_FREQ)
  ) u_fw_calc (
    .i_freq (freq_C2),
    .i_code (w_code),
    .o_fw   (w_fw)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fw   <= '0;
      r_ctrl <= RST_CODE;
    end else begin
      r_fw   <= w_fw;
      r_ctrl <= w_code;
    end
  end

  assign fw           = r_fw;
  assign freq_control = r_ctrl;

endmodule

`default_nettype wire

// File: tb/tb_ddfs_frequency_converter.sv
// tb_ddfs_frequency_converter: directed, sweep and random checks against an arithmetic reference model.
`default_nettype none

module tb_ddfs_frequency_converter;

  localparam longint CLK_HZ = 200000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [22:0] freq_C2 = '0;
  logic [6:0]  fw;
  logic [2:0]  freq_control;

  int n_checks = 0;
  int n_pass   = 0;

  longint ratio [7] = '{2, 10, 100, 1000, 10000, 100000, 1000000};

  ddfs_frequency_converter #(
    .CLK_FREQ (64'(CLK_HZ))
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freq_C2      (freq_C2),
    .fw           (fw),
    .freq_control (freq_control)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Finest range whose output ceiling (f_div/8) still covers the request.
  function automatic int ref_code(input longint f);
    for (int k = 6; k >= 0; k--) begin
      if (f * 8 <= CLK_HZ / ratio[k]) return k;
    end
    return 0;
  endfunction

  function automatic longint ref_n(input longint f, input int code);
    longint d;
    d = CLK_HZ / ratio[code];
`ifdef DDFS_ROUND_EN
    return (2 * f * 1024 + d) / (2 * d);
`else
    return (f * 1024) / d;
`endif
  endfunction

  function automatic int ref_fw(input longint f);
    longint n;
    n = ref_n(f, ref_code(f));
    if (n <= 0)   return 0;
    if (n >= 128) return 127;
    return int'(n - 1);
  endfunction

  task automatic apply_and_check(input string tag, input longint f);
    freq_C2 = 23'(f);
    @(posedge clk);
    #1;
    check({tag, "_code"}, longint'(freq_control), longint'(ref_code(f)));
    check({tag, "_fw"},   longint'(fw),           longint'(ref_fw(f)));
  endtask

  typedef struct {
    longint f;
    int     code;
    int     fw_round;
    int     fw_floor;
  } vec_t;

  vec_t vecs [9] = '{
    '{0,       6, 0,   0},
    '{1000000, 1, 50,  50},
    '{5000000, 0, 50,  50},
    '{250000,  2, 127, 127},
    '{250001,  1, 12,  11},
    '{249999,  2, 127, 126},
    '{100,     5, 50,  50},
    '{10,      6, 50,  50},
    '{250100,  1, 12,  11}
  };

  initial begin
    longint d, err, lim, f;
    int     exp_fw;

    rst_n   = 1'b0;
    freq_C2 = 23'd1000000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_fw",   longint'(fw),           0);
    check("reset_code", longint'(freq_control), 6);

    rst_n   = 1'b1;
    freq_C2 = '0;
    @(posedge clk);
    #1;
    check("release_fw",   longint'(fw),           0);
    check("release_code", longint'(freq_control), 6);

    foreach (vecs[i]) begin
`ifdef DDFS_ROUND_EN
      exp_fw = vecs[i].fw_round;
`else
      exp_fw = vecs[i].fw_floor;
`endif
      freq_C2 = 23'(vecs[i].f);
      @(posedge clk);
      #1;
      check($sformatf("dir%0d_code", vecs[i].f), longint'(freq_control), longint'(vecs[i].code));
      check($sformatf("dir%0d_fw",   vecs[i].f), longint'(fw),           longint'(exp_fw));
    end

    // Reset in mid-stream wins over the computed value.
    freq_C2 = 23'd1000000;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_fw",   longint'(fw),           0);
    check("midrst_code", longint'(freq_control), 6);
    rst_n = 1'b1;
    apply_and_check("after_rst", 1000000);

    for (longint s = 0; s <= 5000000; s += 100) begin
      freq_C2 = 23'(s);
      @(posedge clk);
      #1;
      check("sweep_code", longint'(freq_control), longint'(ref_code(s)));
      check("sweep_fw",   longint'(fw),           longint'(ref_fw(s)));
      if (freq_control == 3'd7) check("sweep_code7", 7, 0);
      if (freq_control != 3'd7 && fw >= 7'd1 && fw <= 7'd126) begin
        d   = CLK_HZ / ratio[freq_control];
        err = 2048 * s - 2 * (longint'(fw) + 1) * d;
        if (err < 0) err = -err;
`ifdef DDFS_ROUND_EN
        lim = d;
`else
        lim = 2 * d;
`endif
        if (err > lim) check($sformatf("sweep_err_%0d", s), err, lim);
      end
    end

    for (int i = 0; i < 2000; i++) begin
      f = (i % 4 == 0) ? longint'($urandom_range(8388607, 0))
                       : longint'($urandom_range(5000000, 0));
      apply_and_check("rand", f);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ddfs_frequency_converter.md
# ddfs_frequency_converter

Converts a requested output frequency in Hz into a 7-bit DDFS frequency word and a 3-bit clock-range selector. It sits between the user frequency entry (two's-complement / unsigned Hz value `freq_C2`) and the DDFS core with its clock-divider bank. The DDFS core produces the frequency (fw+1)·f_div/1024, where f_div is the divided clock chosen by `freq_control`. The block picks the finest range that can reach the request and rounds the word to the nearest step.

## Interface
- `CLK_FREQ`, default 200000000: system clock frequency in Hz, 64-bit. Must be a multiple of 2,000,000.
- `clk` input 1: system clock. Single clock domain.
- `rst_n` input 1: synchronous, active-low reset.
- `freq_C2` input 23: requested frequency in Hz, unsigned, 0..8,388,607. The supported spec range is 0..5,000,000.
- `fw` output 7: frequency word; generated frequency = (fw+1)·f_div/1024.
- `freq_control` output 3: range code; f_div = CLK_FREQ/D[code].
  - D = {2, 10, 100, 1000, 10000, 100000, 1000000} for codes 0..6.
  - Codes 7 is never driven.

## Operation
- Per range k, f_div(k) = CLK_FREQ/D[k] and the reachable maximum is f_max(k) = f_div(k)/8, which corresponds to fw=127.
- Range select: code = largest k in 0..6 with 8·freq_C2 ≤ f_div(k).
  - The comparison is an exact integer compare with no rounding.
  - Equality selects the finer range.
  - If no k qualifies, code 0 is used. This is unreachable for 23-bit input with CLK_FREQ ≥ 134.3 MHz.
- Word: n = round(freq_C2·1024 / f_div(code)), with halves rounded up. Then fw = n−1, saturated to 0..127.
  - n=0 gives fw=0.
  - n=128 gives fw=127.
  - n>128 gives fw=127 (defensive).
- Arithmetic: the product freq_C2·1024 is 33 bits. Divisors are parameter-derived constants.
- freq_C2=0 gives code 6, fw 0.

## Timing
- The input is sampled on every rising `clk`. `fw` and `freq_control` are registered and update on the next rising edge, so latency is 1 cycle.
- Throughput is one new result per cycle. There is no handshake.
- Reset: while `rst_n`=0 at a rising edge, `fw`←0 and `freq_control`←6.
  - Reset asserted mid-stream overrides the computed value on that edge.
  - The first valid result appears on the first edge with `rst_n`=1.
- Both outputs always change on the same edge. A never-valid intermediate pair is never visible.

## Configuration
- `DDFS_ROUND_EN`
  - Defined: n is round-to-nearest (half up), as above.
  - Undefined: n = floor(freq_C2·1024 / f_div); fw = n−1, saturated to 0..127. Range selection is identical in both modes.

## Structure
- Package `ddfs_pkg` holds:
  - the range-count constant (7);
  - the divide-ratio table D;
  - the `FW_W`=7, `FREQ_W`=23 and `CTRL_W`=3 widths;
  - the reset code constant (6).
- Sub-module `ddfs_fw_calc` is combinational. It takes the input and a code and produces the saturated fw, with rounding controlled by `DDFS_ROUND_EN`.
- The top level instantiates the range compare, one `ddfs_fw_calc`, and the output registers.

## Test plan
All cases use CLK_FREQ=200e6 and `DDFS_ROUND_EN` defined; results are checked 1 cycle later.
- Reset: `rst_n`=0 for 2 edges → fw=0, code=6. Release with freq_C2=0 → fw=0, code=6.
- 1,000,000 → code 1, fw 50 (≈996,094 Hz).
- 5,000,000 → code 0, fw 50.
- Range boundary:
  - 250,000 → code 2, fw 127.
  - 250,001 → code 1, fw 12.
  - 249,999 → code 2, fw 127 (saturation of n=128).
- Fine ranges:
  - 100 → code 5, fw 50.
  - 10 → code 6, fw 50.
- Mode check: 250,100 → code 1, fw 12 with rounding. With `DDFS_ROUND_EN` undefined the result is fw 11.
- Sweep 0..5,000,000 in steps of 100, one value per cycle. For every output pair:
  - |freq_C2 − (fw+1)·f_div/1024| ≤ f_div/2048 for all unsaturated points;
  - code is never 7.
